// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit
package pc_pkg;
  typedef enum logic [1:0] {SEQ = 2'd0, REL = 2'd1, ABS = 2'd2, EPC = 2'd3} pc_sel_t;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/pc_target.sv
// pc_target: combinational next-PC target select; misalign flag only with PC_MISALIGN_TRAP_EN
module pc_target
  import pc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH-1:0] epc,
  input  logic [DATA_WIDTH-1:0]    rs1,
  input  logic [DATA_WIDTH-1:0]    immext,
  input  pc_sel_t                  pcsrc,
  output logic [ADDRESS_WIDTH-1:0] target
`ifdef PC_MISALIGN_TRAP_EN
  , output logic                   misalign
`endif
);
  logic [ADDRESS_WIDTH-1:0] imm, rs;
  assign imm = ADDRESS_WIDTH'(immext);
  assign rs  = ADDRESS_WIDTH'(rs1);
  // select the redirect target; register-indirect jumps always clear bit 0
  always_comb
    target = pcsrc == SEQ ? pc + ADDRESS_WIDTH'(PC_STEP) :
             pcsrc == REL ? pc + imm :
             pcsrc == ABS ? (rs + imm) & ~ADDRESS_WIDTH'(1) : epc;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = pcsrc != SEQ && target[1:0] != 2'b00;
`endif
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC register with boot delay, trap/epc, stall and halt; misalign trap via PC_MISALIGN_TRAP_EN
module pc_unit
  import pc_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                       BOOT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  pc_sel_t                  pcsrc,
  input  logic [DATA_WIDTH-1:0]    immext,
  input  logic [DATA_WIDTH-1:0]    rs1,
  input  logic                     trap,
  input  logic [ADDRESS_WIDTH-1:0] trap_vector,
  input  logic                     halt,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pcplus4,
  output logic [ADDRESS_WIDTH-1:0] epc,
  output logic                     fetch_valid,
  output logic                     halted,
  output logic                     misaligned
);
  localparam int CW = $clog2(BOOT_CYCLES + 1);
  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [ADDRESS_WIDTH-1:0] target;
`ifdef PC_MISALIGN_TRAP_EN
  logic                     mis;
`endif
  pc_target #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_target (
    .pc(pc), .epc(epc), .rs1(rs1), .immext(immext), .pcsrc(pcsrc), .target(target)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign(mis)
`endif
  );
  assign pcplus4     = pc + ADDRESS_WIDTH'(PC_STEP);
  assign fetch_valid = state == RUN && !stall && !halt;
  assign halted      = state == HALTED;
`ifndef PC_MISALIGN_TRAP_EN
  assign misaligned  = 1'b0;
`endif
  // boot countdown, then trap > halt > stall > target in RUN; HALTED freezes everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      cnt   <= '0;
      pc    <= RESET_VECTOR;
      epc   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        BOOT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(BOOT_CYCLES - 1)) state <= RUN;
        end
        RUN:
          if (trap) begin
            pc  <= trap_vector;
            epc <= pc;
          end else if (halt) state <= HALTED;
          else if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (mis) begin
              pc         <= trap_vector;
              epc        <= pc;
              misaligned <= 1'b1;
            end else
`endif
            pc <= target;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed checks of pc_unit against a behavioural model
module tb_pc_unit;
  import pc_pkg::*;
  localparam logic [31:0] RV = 32'h1000;
  localparam int BC = 2;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, trap = 1'b0, halt = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [31:0] immext = '0, rs1 = '0, tv = '0;
  logic [31:0] pc, pcplus4, epc;
  logic fetch_valid, halted, misaligned;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_epc;
  int m_boot;
  logic m_halt, m_mis;

  pc_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(RV), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pc_sel_t'(sel)), .immext(immext), .rs1(rs1),
    .trap(trap), .trap_vector(tv), .halt(halt), .pc(pc), .pcplus4(pcplus4), .epc(epc),
    .fetch_valid(fetch_valid), .halted(halted), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = RV; m_epc = '0; m_boot = 0; m_halt = 1'b0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_boot < BC) m_boot++;
      else if (!m_halt) begin
        case (sel)
          2'd0: tgt = m_pc + 32'd4;
          2'd1: tgt = m_pc + immext;
          2'd2: tgt = (rs1 + immext) & 32'hFFFF_FFFE;
          default: tgt = m_epc;
        endcase
        if (trap) begin m_epc = m_pc; m_pc = tv; end
        else if (halt) m_halt = 1'b1;
        else if (!stall) begin
          if (MIS && sel != 2'd0 && tgt[1:0] != 2'b00) begin m_epc = m_pc; m_pc = tv; m_mis = 1'b1; end
          else m_pc = tgt;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pcplus4", pcplus4, m_pc + 32'd4);
    chk("epc", epc, m_epc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_boot == BC && !m_halt && !stall && !halt));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("misaligned", 32'(misaligned), 32'(m_mis));
  end

  initial begin
    repeat (3) tick();
    chk("rst_pc", pc, 32'h1000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1; sel = 2'd0;
    tick(); chk("boot1_fv", 32'(fetch_valid), 32'd0); chk("boot1_pc", pc, 32'h1000);
    tick(); chk("boot2_fv", 32'(fetch_valid), 32'd1); chk("boot2_pc", pc, 32'h1000);
    tick(); chk("seq_pc", pc, 32'h1004);
    repeat (3) tick();
    chk("seq3_pc", pc, 32'h1010);
    sel = 2'd1; immext = 32'hFFFF_FFF8;
    tick(); chk("rel_pc", pc, 32'h1008);
    sel = 2'd3; stall = 1'b1; trap = 1'b1; tv = 32'h100;
    tick(); chk("trapstall_pc", pc, 32'h100); chk("trapstall_epc", epc, 32'h1008);
    stall = 1'b0; trap = 1'b0;
    tick(); chk("epc_ret_pc", pc, 32'h1008);
    sel = 2'd2; rs1 = 32'h2001; immext = 32'd3;
    tick(); chk("abs_pc", pc, 32'h2004);
`ifdef PC_MISALIGN_TRAP_EN
    immext = 32'd1;
    tick(); chk("mis_pc", pc, 32'h100); chk("mis_epc", epc, 32'h2004); chk("mis_flag", 32'(misaligned), 32'd1);
    sel = 2'd0;
    tick(); chk("mis_clear", 32'(misaligned), 32'd0); chk("mis_next_pc", pc, 32'h104);
`endif
    trap = 1'b1; tv = 32'hFFFF_FFFC;
    tick(); trap = 1'b0; sel = 2'd0;
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_pc4", pcplus4, 32'h4);
    for (int i = 0; i < 3000; i++) begin
      stall  = $urandom_range(0, 4) == 0;
      trap   = $urandom_range(0, 19) == 0;
      sel    = 2'($urandom);
      immext = $urandom_range(0, 1) ? 32'($urandom_range(0, 64)) - 32'd32 : 32'($urandom);
      rs1    = 32'($urandom);
      tv     = $urandom_range(0, 7) == 0 ? 32'($urandom) : 32'($urandom) & 32'hFFFF_FFFC;
      tick();
    end
    stall = 1'b0; trap = 1'b1; tv = 32'h1020;
    tick(); chk("pre_halt_pc", pc, 32'h1020);
    trap = 1'b0; halt = 1'b1;
    tick(); chk("halt_pc", pc, 32'h1020); chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      trap = $urandom_range(0, 1) == 1; halt = 1'b0; sel = 2'($urandom); tv = 32'($urandom);
      tick();
      chk("halted_pc", pc, 32'h1020); chk("halted_flag", 32'(halted), 32'd1);
      chk("halted_fv", 32'(fetch_valid), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h1000); chk("async_epc", epc, 32'h0);
    chk("async_halted", 32'(halted), 32'd0); chk("async_fv", 32'(fetch_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1; trap = 1'b0; sel = 2'd0;
    repeat (20) tick();
    chk("reboot_pc", pc, 32'h1000 + 32'd4 * 32'(20 - BC));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
